// File: rtl/vec_bank_mem_if.sv
// Request/response bundle between a vector load-store client and vec_bank_mem.
// The requester drives the request fields and rsp_ready; the memory drives the rest.
interface vec_bank_mem_if #(
  parameter int LANES  = 16,
  parameter int OUT_W  = 32,
  parameter int ADDR_W = 13
);
  logic                        req_valid;
  logic                        req_ready;
  logic                        req_wren;
  logic                        req_vec;
  logic [ADDR_W-1:0]           req_addr;
  logic [LANES-1:0]            req_mask;
  logic [LANES-1:0][OUT_W-1:0] req_data;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [LANES-1:0][OUT_W-1:0] rsp_data;
  logic                        busy;

  modport master (
    output req_valid, req_wren, req_vec, req_addr, req_mask, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  req_valid, req_wren, req_vec, req_addr, req_mask, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/vec_bank_mem.sv
// LANES interleaved single-port banks serving scalar and unaligned vector accesses,
// with a bank-read / S1 / S2 read pipeline that holds under response backpressure.
module vec_bank_mem #(
  parameter int LANES        = 16,
  parameter int DATA_W       = 16,
  parameter int OUT_W        = 32,
  parameter int ADDR_W       = 13,
  parameter bit CLEAR_ON_RST = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  vec_bank_mem_if.slave  bus
);

  localparam int LB    = $clog2(LANES);
  localparam int ROW_W = ADDR_W - LB;
  localparam int ROWS  = 1 << ROW_W;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                      state;
  logic [ROW_W-1:0]            clr_row;
  logic                        busy_q;
  logic                        rsp_valid_q;
  logic [LANES-1:0][OUT_W-1:0] rsp_data_q;
  logic [LANES-1:0][OUT_W-1:0] rot_data;

  logic stall;
  logic accept;
  logic acc_wr;
  logic acc_rd;
  logic clearing;

  logic [LB-1:0]    base_bank;
  logic [ROW_W-1:0] base_row;

  logic [LB-1:0]     lane_of  [LANES];
  logic [ROW_W-1:0]  bank_row [LANES];
  logic [DATA_W-1:0] bank_wd  [LANES];
  logic [LANES-1:0]  bank_we;
  logic [LANES-1:0]  bank_re;

  logic [DATA_W-1:0] mem    [LANES][ROWS];
  logic [DATA_W-1:0] bank_q [LANES];
  logic [DATA_W-1:0] s1_q   [LANES];

  logic          v0;
  logic          v1;
  logic [LB-1:0] rot0;
  logic [LB-1:0] rot1;
  logic          vec0;
  logic          vec1;

  // Upper lane bits of write data are never stored.
  logic unused_bits;
  assign unused_bits = ^bus.req_data;

  assign stall         = rsp_valid_q && !bus.rsp_ready;
  assign bus.req_ready = !stall && (state == RUN);
  assign accept        = bus.req_valid && bus.req_ready && !rst;
  assign acc_wr        = accept && bus.req_wren;
  assign acc_rd        = accept && !bus.req_wren;
  assign clearing      = (state == CLEAR) && !rst;

  assign base_bank = bus.req_addr[LB-1:0];
  assign base_row  = bus.req_addr[ADDR_W-1:LB];

  // Banks below the base bank hold the wrapped tail of the vector, one row further on.
  always_comb begin
    for (int b = 0; b < LANES; b++) begin
      lane_of[b]  = LB'(b) - base_bank;
      bank_row[b] = (LB'(b) >= base_bank) ? base_row : base_row + ROW_W'(1);
      bank_wd[b]  = bus.req_data[lane_of[b]][DATA_W-1:0];
      bank_we[b]  = acc_wr && (bus.req_vec ? bus.req_mask[lane_of[b]]
                                           : (LB'(b) == base_bank));
      bank_re[b]  = acc_rd && (bus.req_vec || (LB'(b) == base_bank));
      if (clearing) begin
        bank_row[b] = clr_row;
        bank_wd[b]  = '0;
        bank_we[b]  = 1'b1;
        bank_re[b]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < LANES; b++) begin
      if (bank_we[b]) mem[b][bank_row[b]] <= bank_wd[b];
      if (bank_re[b]) bank_q[b] <= mem[b][bank_row[b]];
    end
  end

  // Scalar reads mirror the single word onto the first and last lanes.
  always_comb begin
    rot_data = '0;
    if (vec1) begin
      for (int i = 0; i < LANES; i++) begin
        rot_data[i][DATA_W-1:0] = s1_q[LB'(i) + rot1];
      end
    end else begin
      rot_data[0][DATA_W-1:0]       = s1_q[rot1];
      rot_data[LANES-1][DATA_W-1:0] = s1_q[rot1];
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      if (acc_rd) begin
        rot0 <= base_bank;
        vec0 <= bus.req_vec;
      end
      s1_q <= bank_q;
      rot1 <= rot0;
      vec1 <= vec0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= CLEAR_ON_RST ? CLEAR : RUN;
      busy_q      <= CLEAR_ON_RST;
      clr_row     <= '0;
      v0          <= 1'b0;
      v1          <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state)
        CLEAR: begin
          clr_row <= clr_row + ROW_W'(1);
          if (clr_row == ROW_W'(ROWS - 1)) begin
            state  <= RUN;
            busy_q <= 1'b0;
          end
        end
        default: ;
      endcase
      if (!stall) begin
        v0          <= acc_rd;
        v1          <= v0;
        rsp_valid_q <= v1;
        if (v1) rsp_data_q <= rot_data;
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_vec_bank_mem.sv
// Directed bench for vec_bank_mem: post-reset clear, vector/scalar table vectors,
// response backpressure and reset in the middle of a read.
module tb_vec_bank_mem;

  localparam int LANES  = 16;
  localparam int DATA_W = 16;
  localparam int OUT_W  = 32;
  localparam int ADDR_W = 13;
  localparam int VW     = LANES * OUT_W;
  localparam int NVEC   = 13;

  typedef logic [LANES-1:0][OUT_W-1:0] lanes_t;
  typedef logic [VW-1:0] wide_t;

  typedef struct {
    logic              wren;
    logic              vec;
    logic [ADDR_W-1:0] addr;
    logic [LANES-1:0]  mask;
    lanes_t            data;
    lanes_t            exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  vec_t tbl [NVEC];

  vec_bank_mem_if #(.LANES(LANES), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) bus ();

  vec_bank_mem #(
    .LANES(LANES), .DATA_W(DATA_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W), .CLEAR_ON_RST(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input wide_t act, input wide_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic lanes_t seq(input logic [OUT_W-1:0] base);
    lanes_t r;
    for (int i = 0; i < LANES; i++) r[i] = base + OUT_W'(i);
    return r;
  endfunction

  function automatic lanes_t fill(input logic [OUT_W-1:0] v);
    lanes_t r;
    for (int i = 0; i < LANES; i++) r[i] = v;
    return r;
  endfunction

  function automatic lanes_t scal(input logic [OUT_W-1:0] v);
    lanes_t r;
    r = '0;
    r[0] = v;
    r[LANES-1] = v;
    return r;
  endfunction

  task automatic setVec(input int k, input logic wren, input logic vec,
                        input logic [ADDR_W-1:0] addr, input logic [LANES-1:0] mask,
                        input lanes_t data, input lanes_t exp);
    tbl[k].wren = wren;
    tbl[k].vec  = vec;
    tbl[k].addr = addr;
    tbl[k].mask = mask;
    tbl[k].data = data;
    tbl[k].exp  = exp;
  endtask

  // Called at a falling edge; returns at the falling edge after the accepting edge.
  task automatic applyStimulus(input logic wren, input logic vec, input logic [ADDR_W-1:0] addr,
                               input logic [LANES-1:0] mask, input lanes_t data, output bit ok);
    int n;
    bus.req_valid = 1'b1;
    bus.req_wren  = wren;
    bus.req_vec   = vec;
    bus.req_addr  = addr;
    bus.req_mask  = mask;
    bus.req_data  = data;
    n = 0;
    while (!bus.req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL req_timeout: got req_ready=0, expected 1 within 1000 cycles");
      bus.req_valid = 1'b0;
      ok = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    ok = 1'b1;
  endtask

  task automatic awaitResponse(input string name, input lanes_t exp);
    int lat;
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({name, "_lat"}, wide_t'(lat), wide_t'(2));
    checkOutput({name, "_data"}, bus.rsp_data, exp);
    @(negedge clk);
    checkOutput({name, "_once"}, wide_t'(bus.rsp_valid), wide_t'(0));
  endtask

  // One-cycle reset, then checks reset values and the length of the clear sweep.
  task automatic doReset(input string name);
    int  n;
    bit  saw_ready;
    bit  saw_valid;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput({name, "_busy"}, wide_t'(bus.busy), wide_t'(1));
    checkOutput({name, "_ready"}, wide_t'(bus.req_ready), wide_t'(0));
    checkOutput({name, "_rspv"}, wide_t'(bus.rsp_valid), wide_t'(0));
    checkOutput({name, "_rspd"}, bus.rsp_data, wide_t'(0));
    n = 0;
    saw_ready = 1'b0;
    saw_valid = 1'b0;
    while (bus.busy && n < 2000) begin
      if (bus.req_ready) saw_ready = 1'b1;
      if (bus.rsp_valid) saw_valid = 1'b1;
      n++;
      @(negedge clk);
    end
    checkOutput({name, "_clear_len"}, wide_t'(n), wide_t'(512));
    checkOutput({name, "_ready_in_clear"}, wide_t'(saw_ready), wide_t'(0));
    checkOutput({name, "_rspv_in_clear"}, wide_t'(saw_valid), wide_t'(0));
    checkOutput({name, "_ready_after"}, wide_t'(bus.req_ready), wide_t'(1));
  endtask

  initial begin
    lanes_t    e_unal;
    lanes_t    e_mask;
    lanes_t    d_scal;
    lanes_t    bp_exp [3];
    lanes_t    got [$];
    bit        ok;

    e_unal = '0;
    for (int i = 0; i < 12; i++) e_unal[i] = 32'h0000A004 + 32'(i);
    e_mask = fill(32'h00005555);
    for (int i = 4; i < 8; i++) e_mask[i] = 32'h0000EEEE;
    e_mask[1] = 32'h00001234;
    d_scal = seq(32'h0000BAD0);
    d_scal[0] = 32'hFFFF1234;

    setVec(0,  1'b0, 1'b1, 13'h0000, 16'hFFFF, '0,                   fill(32'h0));
    setVec(1,  1'b1, 1'b1, 13'h0020, 16'hFFFF, seq(32'h00001000),    '0);
    setVec(2,  1'b0, 1'b1, 13'h0020, 16'hFFFF, '0,                   seq(32'h00001000));
    setVec(3,  1'b1, 1'b1, 13'h1FF8, 16'hFFFF, seq(32'h7777A000),    '0);
    setVec(4,  1'b0, 1'b1, 13'h1FF8, 16'hFFFF, '0,                   seq(32'h0000A000));
    setVec(5,  1'b0, 1'b0, 13'h0003, 16'hFFFF, '0,                   scal(32'h0000A00B));
    setVec(6,  1'b0, 1'b0, 13'h1FFF, 16'hFFFF, '0,                   scal(32'h0000A007));
    setVec(7,  1'b0, 1'b1, 13'h1FFC, 16'hFFFF, '0,                   e_unal);
    setVec(8,  1'b1, 1'b1, 13'h0040, 16'hFFFF, fill(32'h00005555),   '0);
    setVec(9,  1'b1, 1'b1, 13'h0040, 16'h00F0, fill(32'h0000EEEE),   '0);
    setVec(10, 1'b1, 1'b0, 13'h0041, 16'h0000, d_scal,               '0);
    setVec(11, 1'b0, 1'b1, 13'h0040, 16'hFFFF, '0,                   e_mask);
    setVec(12, 1'b0, 1'b0, 13'h0041, 16'hFFFF, '0,                   scal(32'h00001234));

    bus.req_valid = 1'b0;
    bus.req_wren  = 1'b0;
    bus.req_vec   = 1'b0;
    bus.req_addr  = '0;
    bus.req_mask  = '0;
    bus.req_data  = '0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    doReset("rst_init");

    for (int k = 0; k < NVEC; k++) begin
      applyStimulus(tbl[k].wren, tbl[k].vec, tbl[k].addr, tbl[k].mask, tbl[k].data, ok);
      if (ok && !tbl[k].wren) awaitResponse($sformatf("vec%0d", k), tbl[k].exp);
    end

    // Backpressure: three reads queue up behind a stalled response.
    bp_exp[0] = '0;
    for (int i = 0; i < 8; i++) bp_exp[0][i] = 32'h0000A008 + 32'(i);
    bp_exp[1] = fill(32'h0);
    bp_exp[2] = seq(32'h00001000);
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, ADDR_W'(k * 16), 16'hFFFF, '0, ok);
    end
    checkOutput("bp_valid", wide_t'(bus.rsp_valid), wide_t'(1));
    checkOutput("bp_ready_low", wide_t'(bus.req_ready), wide_t'(0));
    checkOutput("bp_first", bus.rsp_data, bp_exp[0]);
    repeat (3) @(negedge clk);
    checkOutput("bp_hold_valid", wide_t'(bus.rsp_valid), wide_t'(1));
    checkOutput("bp_hold_data", bus.rsp_data, bp_exp[0]);
    checkOutput("bp_hold_ready", wide_t'(bus.req_ready), wide_t'(0));
    bus.rsp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (bus.rsp_valid) got.push_back(bus.rsp_data);
      @(negedge clk);
    end
    checkOutput("bp_count", wide_t'(got.size()), wide_t'(3));
    for (int k = 0; k < 3; k++) begin
      if (k < got.size()) checkOutput($sformatf("bp_rsp%0d", k), got[k], bp_exp[k]);
    end
    checkOutput("bp_ready_back", wide_t'(bus.req_ready), wide_t'(1));

    // Reset one cycle after a read is accepted: the read must vanish and memory re-clear.
    applyStimulus(1'b0, 1'b1, 13'h0020, 16'hFFFF, '0, ok);
    doReset("rst_mid");
    applyStimulus(1'b0, 1'b1, 13'h0020, 16'hFFFF, '0, ok);
    if (ok) awaitResponse("rd_after_clear", fill(32'h0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
